if_trace_queue: RTL

- Successor to the single-fetch IF tracker. Passively monitors the instruction-fetch stage and the OBI-style instruction memory port, with up to MAX_OUTSTANDING fetches in flight.
- For each completed fetch, builds one trace record: address, instruction, stage-start time, memory-request time and end time.
- Buffers records in an output FIFO with a valid/ready drain interface toward the trace aggregator.
- Never stalls the core. On overflow it drops records and counts them.

---
 rtl/if_trace_queue.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/if_trace_queue.sv
// Generic FIFO: a push is visible on dout the next cycle, and a push at full is legal with a same-cycle pop.
// A push to a full FIFO without a pop is ignored; the caller owns the drop policy.
module itq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// Passive IF-stage fetch tracer: pairs in-order responses with pending fetches into timestamped records.
// Record visible one cycle after rvalid; never stalls the core, drains via valid/ready and drops on overflow.
module if_trace_queue #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIME_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int OUT_DEPTH       = 8,
  parameter int DROP_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_en,
  input  logic                  if_busy,
  input  logic                  if_ready,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_grant,
  input  logic                  instr_rvalid,
  input  logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic [TIME_WIDTH-1:0] counter,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [ADDR_WIDTH-1:0] trace_addr,
  output logic [DATA_WIDTH-1:0] trace_instr,
  output logic [TIME_WIDTH-1:0] trace_if_start,
  output logic [TIME_WIDTH-1:0] trace_mem_start,
  output logic [TIME_WIDTH-1:0] trace_end,
  output logic [DROP_WIDTH-1:0] drop_count,
  output logic                  overflow,
  output logic                  proto_err
);
  typedef enum logic {IDLE, REQ_WAIT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [TIME_WIDTH-1:0] if_start;
    logic [TIME_WIDTH-1:0] mem_start;
  } pend_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] instr;
    logic [TIME_WIDTH-1:0] if_start;
    logic [TIME_WIDTH-1:0] mem_start;
    logic [TIME_WIDTH-1:0] end_time;
  } rec_t;

  state_t                state;
  state_t                state_d;
  logic [TIME_WIDTH-1:0] req_time;
  logic [TIME_WIDTH-1:0] mem_time;
  logic [TIME_WIDTH-1:0] stage_start;
  logic                  stage_active;
  logic                  stage_active_q;
  logic                  accept;
  logic                  accept_q;

  pend_t pend_in;
  pend_t pend_out;
  pend_t pend_src;
  rec_t  rec_in;
  rec_t  rec_out;
  logic  pend_empty;
  logic  pend_full;
  logic  pend_pop;
  logic  pend_push;
  logic  pend_drop;
  logic  rec_vld;
  logic  orphan_rsp;
  logic  out_empty;
  logic  out_full;
  logic  out_pop;
  logic  out_push;
  logic  out_drop;

  logic [1:0]          drop_inc;
  logic [DROP_WIDTH:0] drop_sum;

  assign stage_active = if_busy | if_ready;

  // Stage start re-arms on the rising edge of activity and after every accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_active_q <= 1'b0;
      accept_q       <= 1'b0;
      stage_start    <= '0;
    end else begin
      stage_active_q <= stage_active;
      accept_q       <= accept;
      if (stage_active && (!stage_active_q || accept_q)) stage_start <= counter;
    end
  end

  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    mem_time = counter;
    case (state)
      IDLE: begin
        if (instr_req && trace_en) begin
          if (instr_grant) accept  = 1'b1;
          else             state_d = REQ_WAIT;
        end
      end
      REQ_WAIT: begin
        mem_time = req_time;
        if (instr_req && instr_grant) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else if (!instr_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_time <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && instr_req && trace_en && !instr_grant) req_time <= counter;
    end
  end

  assign pend_in = '{addr: instr_addr, if_start: stage_start, mem_start: mem_time};

  // A response arriving with an empty queue consumes the fetch accepted in the same cycle.
  assign pend_pop   = instr_rvalid && !pend_empty;
  assign pend_drop  = accept && !pend_empty && pend_full && !pend_pop;
  assign pend_push  = accept && !(instr_rvalid && pend_empty) && !pend_drop;
  assign rec_vld    = instr_rvalid && (!pend_empty || accept);
  assign orphan_rsp = instr_rvalid && pend_empty && !accept;
  assign pend_src   = pend_empty ? pend_in : pend_out;

  assign rec_in = '{addr: pend_src.addr, instr: instr_rdata, if_start: pend_src.if_start,
                    mem_start: pend_src.mem_start, end_time: counter};

  assign out_pop  = trace_valid && trace_ready;
  assign out_drop = rec_vld && out_full && !out_pop;
  assign out_push = rec_vld && !out_drop;

  itq_fifo #(.W($bits(pend_t)), .DEPTH(MAX_OUTSTANDING)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .push  (pend_push),
    .din   (pend_in),
    .pop   (pend_pop),
    .dout  (pend_out),
    .empty (pend_empty),
    .full  (pend_full)
  );

  itq_fifo #(.W($bits(rec_t)), .DEPTH(OUT_DEPTH)) u_out (
    .clk   (clk),
    .rst   (rst),
    .push  (out_push),
    .din   (rec_in),
    .pop   (out_pop),
    .dout  (rec_out),
    .empty (out_empty),
    .full  (out_full)
  );

  assign drop_inc = {1'b0, pend_drop} + {1'b0, out_drop};
  assign drop_sum = {1'b0, drop_count} + {{(DROP_WIDTH-1){1'b0}}, drop_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      if (drop_inc != 2'd0) begin
        drop_count <= drop_sum[DROP_WIDTH] ? '1 : drop_sum[DROP_WIDTH-1:0];
        overflow   <= 1'b1;
      end
      if (orphan_rsp) proto_err <= 1'b1;
    end
  end

  // Record fields are forced to zero while empty so reset and idle outputs read as 0.
  assign trace_valid     = !out_empty;
  assign trace_addr      = trace_valid ? rec_out.addr      : '0;
  assign trace_instr     = trace_valid ? rec_out.instr     : '0;
  assign trace_if_start  = trace_valid ? rec_out.if_start  : '0;
  assign trace_mem_start = trace_valid ? rec_out.mem_start : '0;
  assign trace_end       = trace_valid ? rec_out.end_time  : '0;
endmodule
